ro_puf_sequencer: RTL and testbench

- Measurement controller for the ring-oscillator PUF array.
- Per challenge, it steps through RESP_BITS RO pairs. For each pair it:
  - drives the two RO-select muxes,
  - clears both frequency counters,
  - enables the oscillators for a fixed gate window,
  - waits for the counters to settle,
  - compares the two counts to produce one response bit.
- It sits between the host/challenge interface and the RO mux plus COUNTER pair. It owns all timing of the RO datapath.

---
 rtl/ro_puf_pkg.sv | 31 +++
 rtl/ro_puf_sequencer_if.sv | 39 +++
 rtl/ro_pair_compare.sv | 18 +
 rtl/ro_puf_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ro_puf_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_pkg.sv
// ---------------------------------------------------------------------------
// ro_puf_pkg
// Shared definitions for the ring-oscillator PUF measurement logic:
//   - state_t      : measurement sequencer states
//   - DEF_*        : default timing constants (gate window, settle, clear)
//   - ro_sel()     : RO index helper, base + offset wrapped to the array size
// ---------------------------------------------------------------------------
package ro_puf_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam int unsigned DEF_WINDOW  = 1024;
   localparam int unsigned DEF_SETTLE  = 4;
   localparam int unsigned DEF_CLR_CYC = 2;

   // The array size is a power of two, so masking with num_ro-1 is the same
   // wrap as truncating the sum to SEL_W bits; callers truncate the result.
   function automatic logic [31:0] ro_sel(input logic [31:0] base,
                                          input logic [31:0] offset,
                                          input int unsigned num_ro);
      return (base + offset) & (num_ro - 32'd1);
   endfunction

endpackage

// File: rtl/ro_puf_sequencer_if.sv
// ---------------------------------------------------------------------------
// ro_puf_sequencer_if
// Bundles the host/challenge side and the RO-datapath side of the sequencer.
//   Start, Challenge        : host request and base RO index
//   Busy, Valid             : status / one-cycle completion pulse
//   Response, Tie           : response word and per-bit tie flags
//   SelA, SelB              : RO mux selects for counters A and B
//   RoEnable, CntReset      : oscillator gate and counter clear
//   CountA, CountB          : frequency counter results
// Modports: slave = sequencer, master = host plus RO datapath.
// ---------------------------------------------------------------------------
interface ro_puf_sequencer_if #(
   parameter int unsigned SEL_W     = 4,
   parameter int unsigned CNT_SIZE  = 32,
   parameter int unsigned RESP_BITS = 8
);
   logic                 Start;
   logic [SEL_W-1:0]     Challenge;
   logic [CNT_SIZE-1:0]  CountA;
   logic [CNT_SIZE-1:0]  CountB;
   logic [SEL_W-1:0]     SelA;
   logic [SEL_W-1:0]     SelB;
   logic                 RoEnable;
   logic                 CntReset;
   logic                 Busy;
   logic                 Valid;
   logic [RESP_BITS-1:0] Response;
   logic [RESP_BITS-1:0] Tie;

   modport slave (
      input  Start, Challenge, CountA, CountB,
      output SelA, SelB, RoEnable, CntReset, Busy, Valid, Response, Tie
   );

   modport master (
      output Start, Challenge, CountA, CountB,
      input  SelA, SelB, RoEnable, CntReset, Busy, Valid, Response, Tie
   );
endinterface

// File: rtl/ro_pair_compare.sv
// ---------------------------------------------------------------------------
// ro_pair_compare
// Combinational comparison of one RO pair's frequency counts.
//   count_a, count_b : unsigned counts
//   gt               : count_a > count_b
//   eq               : count_a == count_b
// ---------------------------------------------------------------------------
module ro_pair_compare #(
   parameter int unsigned CNT_SIZE = 32
) (
   input  logic [CNT_SIZE-1:0] count_a,
   input  logic [CNT_SIZE-1:0] count_b,
   output logic                gt,
   output logic                eq
);
   assign gt = (count_a > count_b);
   assign eq = (count_a == count_b);
endmodule

// File: rtl/ro_puf_sequencer.sv
// ---------------------------------------------------------------------------
// ro_puf_sequencer
// Measurement controller for the RO PUF array. For each of RESP_BITS RO pairs
// it selects the pair, clears the counters, gates the oscillators for WINDOW
// cycles, waits SETTLE cycles and captures one response bit.
//   Clock : system clock
//   Reset : synchronous active-low reset
//   bus   : ro_puf_sequencer_if.slave (host + RO datapath signals)
// All outputs are registers; control outputs are decoded from the next state.
// ---------------------------------------------------------------------------
module ro_puf_sequencer
   import ro_puf_pkg::*;
#(
   parameter int unsigned CNT_SIZE  = 32,
   parameter int unsigned NUM_RO    = 16,
   parameter int unsigned SEL_W     = 4,
   parameter int unsigned RESP_BITS = 8,
   parameter int unsigned WINDOW    = DEF_WINDOW,
   parameter int unsigned SETTLE    = DEF_SETTLE,
   parameter int unsigned CLR_CYC   = DEF_CLR_CYC
) (
   input  logic                Clock,
   input  logic                Reset,
   ro_puf_sequencer_if.slave   bus
);

   localparam int unsigned MAX_DUR = (WINDOW > SETTLE) ?
                                     ((WINDOW > CLR_CYC) ? WINDOW : CLR_CYC) :
                                     ((SETTLE > CLR_CYC) ? SETTLE : CLR_CYC);
   localparam int unsigned T_W = $clog2(MAX_DUR + 1);
   localparam int unsigned K_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

   localparam logic [T_W-1:0] T_CLR    = T_W'(CLR_CYC - 1);
   localparam logic [T_W-1:0] T_WINDOW = T_W'(WINDOW - 1);
   localparam logic [T_W-1:0] T_SETTLE = T_W'(SETTLE - 1);
   localparam logic [K_W-1:0] K_LAST   = K_W'(RESP_BITS - 1);

   state_t               state_q, state_d;
   logic [T_W-1:0]       timer_q, timer_d;   // cycles left in current state
   logic [K_W-1:0]       k_q, k_d;           // current pair index
   logic [SEL_W-1:0]     base_q, base_d;
   logic [SEL_W-1:0]     sel_a_q, sel_a_d;
   logic [SEL_W-1:0]     sel_b_q, sel_b_d;
   logic [RESP_BITS-1:0] resp_q, resp_d;
   logic [RESP_BITS-1:0] tie_q, tie_d;
   logic                 ro_en_q, cnt_rst_q, busy_q, valid_q;
   logic                 cmp_gt, cmp_eq;

   ro_pair_compare #(.CNT_SIZE(CNT_SIZE)) u_cmp (
      .count_a (bus.CountA),
      .count_b (bus.CountB),
      .gt      (cmp_gt),
      .eq      (cmp_eq)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      timer_d = timer_q;
      k_d     = k_q;
      base_d  = base_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      resp_d  = resp_q;
      tie_d   = tie_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               base_d  = bus.Challenge;
               k_d     = '0;
               resp_d  = '0;
               tie_d   = '0;
               sel_a_d = SEL_W'(ro_sel(32'(bus.Challenge), 32'd0, NUM_RO));
               sel_b_d = SEL_W'(ro_sel(32'(bus.Challenge), 32'd1, NUM_RO));
               timer_d = T_CLR;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (timer_q == '0) begin
               timer_d = T_WINDOW;
               state_d = S_RUN;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_RUN: begin
            if (timer_q == '0) begin
               timer_d = T_SETTLE;
               state_d = S_SETTLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_SETTLE: begin
            if (timer_q == '0) begin
               timer_d = '0;
               state_d = S_CAPTURE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_CAPTURE: begin
            // A tie always yields a 0 response bit since gt is false.
            resp_d[k_q] = cmp_gt;
            tie_d[k_q]  = cmp_eq;
            if (k_q == K_LAST) begin
               state_d = S_DONE;
            end else begin
               k_d     = k_q + 1'b1;
               sel_a_d = SEL_W'(ro_sel(32'(base_q), (32'(k_q) + 32'd1) << 1, NUM_RO));
               sel_b_d = SEL_W'(ro_sel(32'(base_q), ((32'(k_q) + 32'd1) << 1) + 32'd1, NUM_RO));
               timer_d = T_CLR;
               state_d = S_CLEAR;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         // NOTE: the reset clears every flop here, including the response
         // registers, so no output is X once reset has been seen.
         state_q   <= S_IDLE;
         timer_q   <= '0;
         k_q       <= '0;
         base_q    <= '0;
         sel_a_q   <= '0;
         sel_b_q   <= '0;
         resp_q    <= '0;
         tie_q     <= '0;
         ro_en_q   <= 1'b0;
         cnt_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         k_q       <= k_d;
         base_q    <= base_d;
         sel_a_q   <= sel_a_d;
         sel_b_q   <= sel_b_d;
         resp_q    <= resp_d;
         tie_q     <= tie_d;
         // Decoding from the next state keeps these registered yet aligned
         // with the state they belong to.
         ro_en_q   <= (state_d == S_RUN);
         cnt_rst_q <= (state_d == S_CLEAR);
         busy_q    <= (state_d != S_IDLE);
         valid_q   <= (state_d == S_DONE);
      end
   end

   assign bus.SelA     = sel_a_q;
   assign bus.SelB     = sel_b_q;
   assign bus.RoEnable = ro_en_q;
   assign bus.CntReset = cnt_rst_q;
   assign bus.Busy     = busy_q;
   assign bus.Valid    = valid_q;
   assign bus.Response = resp_q;
   assign bus.Tie      = tie_q;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ro_puf_sequencer
// Self-checking bench for ro_puf_sequencer with a small configuration
// (8 ROs, 4 response bits, 8-cycle window). Counter values come from a
// per-RO table indexed by the DUT selects; expectations come from a pair-wise
// reference model and timing formulas.
// ---------------------------------------------------------------------------
module tb_ro_puf_sequencer;

   localparam int unsigned NRO = 8;
   localparam int unsigned SW  = 3;
   localparam int unsigned RB  = 4;
   localparam int unsigned WIN = 8;
   localparam int unsigned STL = 2;
   localparam int unsigned CLR = 2;
   localparam int LAT    = RB * (CLR + WIN + STL + 1) + 1;  // 53
   localparam int PERIOD = 54;                               // Start held high

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   int   cyc   = 0;
   int   vectors = 0;
   int   fails   = 0;

   logic [31:0] ro_cnt [NRO];

   ro_puf_sequencer_if #(.SEL_W(SW), .CNT_SIZE(32), .RESP_BITS(RB)) bus ();

   ro_puf_sequencer #(
      .CNT_SIZE(32), .NUM_RO(NRO), .SEL_W(SW), .RESP_BITS(RB),
      .WINDOW(WIN), .SETTLE(STL), .CLR_CYC(CLR)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   assign bus.CountA = ro_cnt[bus.SelA];
   assign bus.CountB = ro_cnt[bus.SelB];

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // ---------------- monitor ----------------
   bit          prev_en, prev_clr;
   int          en_len, clr_len, overlap;
   int          en_runs[$], clr_runs[$], valid_cyc[$];
   logic [2*SW-1:0] sel_log[$];
   logic [RB-1:0]   vresp[$], vtie[$];

   always @(negedge Clock) begin
      prev_en  <= bus.RoEnable;
      prev_clr <= bus.CntReset && bus.Busy;
      if (bus.RoEnable) en_len <= en_len + 1;
      else if (prev_en) begin
         en_runs.push_back(en_len);
         en_len <= 0;
      end
      if (bus.CntReset && bus.Busy) begin
         clr_len <= clr_len + 1;
         if (!prev_clr) sel_log.push_back({bus.SelA, bus.SelB});
      end else if (prev_clr) begin
         clr_runs.push_back(clr_len);
         clr_len <= 0;
      end
      if (bus.RoEnable && bus.CntReset) overlap <= overlap + 1;
      if (bus.Valid) begin
         valid_cyc.push_back(cyc);
         vresp.push_back(bus.Response);
         vtie.push_back(bus.Tie);
      end
   end

   // ---------------- reference model ----------------
   // Returns {tie, response} for a challenge using the current count table.
   function automatic logic [2*RB-1:0] model(input logic [SW-1:0] base);
      logic [RB-1:0] r, t;
      int a, b;
      r = '0;
      t = '0;
      for (int k = 0; k < RB; k++) begin
         a = (int'(base) + 2 * k) % NRO;
         b = (int'(base) + 2 * k + 1) % NRO;
         r[k] = ro_cnt[a] > ro_cnt[b];
         t[k] = ro_cnt[a] == ro_cnt[b];
      end
      return {t, r};
   endfunction

   function automatic logic [2*SW-1:0] exp_sel(input logic [SW-1:0] base, input int k);
      int a, b;
      a = (int'(base) + 2 * k) % NRO;
      b = (int'(base) + 2 * k + 1) % NRO;
      return {SW'(a), SW'(b)};
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      en_runs.delete();
      clr_runs.delete();
      valid_cyc.delete();
      sel_log.delete();
      vresp.delete();
      vtie.delete();
   endtask

   task automatic measure(input logic [SW-1:0] ch, input bit pulse,
                          output int lat, output bit got);
      int st;
      clear_logs();
      @(negedge Clock);
      bus.Challenge = ch;
      bus.Start     = 1'b1;
      st  = cyc;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge Clock);
         bus.Start = pulse && ((cyc - st) == 10 || (cyc - st) == 30);
         if (valid_cyc.size() > 0) got = 1'b1;
      end
      bus.Start = 1'b0;
      lat = got ? (valid_cyc[0] - st) : -1;
   endtask

   task automatic randomize_counts(input int unsigned hi);
      for (int i = 0; i < NRO; i++) ro_cnt[i] = $urandom_range(hi, 0);
   endtask

   // ---------------- stimulus ----------------
   int            lat, st, n, ov0;
   bit            got;
   logic [SW-1:0] ch;
   logic [SW-1:0] chs [3];
   logic [2*RB-1:0] exp_tr;

   initial begin
      bus.Start     = 1'b0;
      bus.Challenge = '0;
      ro_cnt = '{32'd10, 32'd5, 32'd3, 32'd9, 32'd7, 32'd7, 32'd12, 32'd1};

      // Reset state
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      check("rst_busy",     bus.Busy,     1'b0);
      check("rst_valid",    bus.Valid,    1'b0);
      check("rst_roen",     bus.RoEnable, 1'b0);
      check("rst_cntreset", bus.CntReset, 1'b1);
      check("rst_resp",     bus.Response, '0);
      check("rst_tie",      bus.Tie,      '0);
      check("rst_sel",      {bus.SelA, bus.SelB}, '0);
      Reset = 1'b1;
      @(negedge Clock);
      check("idle_cntreset", bus.CntReset, 1'b0);

      // Basic measurement with the fixed count table
      ov0 = overlap;
      measure(3'd0, 1'b0, lat, got);
      check("basic_valid", got, 1'b1);
      check("basic_lat",   lat, LAT);
      check("basic_resp",  bus.Response, 4'b1001);
      check("basic_tie",   bus.Tie,      4'b0100);
      check("basic_nen",   en_runs.size(),  RB);
      check("basic_nclr",  clr_runs.size(), RB);
      for (int i = 0; i < RB; i++) begin
         check($sformatf("basic_en_len%0d", i),  en_runs[i],  WIN);
         check($sformatf("basic_clr_len%0d", i), clr_runs[i], CLR);
      end
      check("basic_overlap", overlap - ov0, 0);

      // Wrap-around selects
      randomize_counts(100);
      ov0 = overlap;
      measure(3'd5, 1'b0, lat, got);
      exp_tr = model(3'd5);
      check("wrap_nsel", sel_log.size(), RB);
      for (int k = 0; k < RB; k++)
         check($sformatf("wrap_sel%0d", k), sel_log[k], exp_sel(3'd5, k));
      check("wrap_resp", bus.Response, exp_tr[RB-1:0]);
      check("wrap_tie",  bus.Tie,      exp_tr[2*RB-1:RB]);
      check("wrap_lat",  lat, LAT);
      for (int i = 0; i < RB; i++) begin
         check($sformatf("wrap_en_len%0d", i),  en_runs[i],  WIN);
         check($sformatf("wrap_clr_len%0d", i), clr_runs[i], CLR);
      end
      check("wrap_overlap", overlap - ov0, 0);

      // Start pulses while busy
      randomize_counts(3);
      ch = SW'($urandom_range(NRO - 1, 0));
      measure(ch, 1'b1, lat, got);
      repeat (60) @(negedge Clock);
      exp_tr = model(ch);
      check("busy_lat",    lat, LAT);
      check("busy_nvalid", valid_cyc.size(), 1);
      check("busy_resp",   bus.Response, exp_tr[RB-1:0]);
      check("busy_tie",    bus.Tie,      exp_tr[2*RB-1:RB]);

      // Reset during the RUN phase of pair 2
      ro_cnt = '{32'd10, 32'd5, 32'd3, 32'd9, 32'd7, 32'd7, 32'd12, 32'd1};
      clear_logs();
      @(negedge Clock);
      bus.Challenge = 3'd0;
      bus.Start     = 1'b1;
      st = cyc;
      @(negedge Clock);
      bus.Start = 1'b0;
      while (cyc < st + 32) @(negedge Clock);
      check("mid_run_roen", bus.RoEnable, 1'b1);
      check("mid_run_resp", bus.Response, 4'b0001);
      Reset = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      check("abort_busy",     bus.Busy,     1'b0);
      check("abort_resp",     bus.Response, '0);
      check("abort_tie",      bus.Tie,      '0);
      check("abort_cntreset", bus.CntReset, 1'b1);
      check("abort_roen",     bus.RoEnable, 1'b0);
      repeat (70) @(negedge Clock);
      check("abort_no_valid", valid_cyc.size(), 0);
      measure(3'd2, 1'b0, lat, got);
      exp_tr = model(3'd2);
      check("after_abort_lat",  lat, LAT);
      check("after_abort_resp", bus.Response, exp_tr[RB-1:0]);
      check("after_abort_tie",  bus.Tie,      exp_tr[2*RB-1:RB]);

      // Back-to-back with Start held high
      randomize_counts(1000);
      for (int i = 0; i < 3; i++) chs[i] = SW'($urandom_range(NRO - 1, 0));
      clear_logs();
      @(negedge Clock);
      bus.Challenge = chs[0];
      bus.Start     = 1'b1;
      n = 0;
      for (int i = 0; i < 250 && valid_cyc.size() < 3; i++) begin
         @(negedge Clock);
         if (valid_cyc.size() > n) begin
            n = valid_cyc.size();
            if (n < 3) bus.Challenge = chs[n];
         end
      end
      bus.Start = 1'b0;
      check("b2b_nvalid", valid_cyc.size(), 3);
      for (int i = 1; i < 3; i++)
         check($sformatf("b2b_period%0d", i), valid_cyc[i] - valid_cyc[i-1], PERIOD);
      for (int i = 0; i < 3; i++) begin
         exp_tr = model(chs[i]);
         check($sformatf("b2b_resp%0d", i), vresp[i], exp_tr[RB-1:0]);
         check($sformatf("b2b_tie%0d", i),  vtie[i],  exp_tr[2*RB-1:RB]);
      end
      repeat (3) @(negedge Clock);

      // Randomized measurements, small count range to provoke ties
      for (int r = 0; r < 6; r++) begin
         randomize_counts((r % 2 == 0) ? 3 : 32'hFFFF);
         ch = SW'($urandom_range(NRO - 1, 0));
         measure(ch, 1'b0, lat, got);
         exp_tr = model(ch);
         check($sformatf("rnd%0d_lat", r),  lat, LAT);
         check($sformatf("rnd%0d_resp", r), bus.Response, exp_tr[RB-1:0]);
         check($sformatf("rnd%0d_tie", r),  bus.Tie,      exp_tr[2*RB-1:RB]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
